// File: rtl/dadda_multiplier.sv
// Unsigned 4x4 Dadda-tree multiplier with a registered 8-bit product.
// Define DADDA_INPUT_REG_EN to register A/B first (latency 2 instead of 1).
module dadda_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module dadda_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ ci;
  assign c = (a & b) | (ci & (a ^ b));
endmodule

module dadda_multiplier (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] product
);
  logic [3:0]      w_a, w_b;
  logic [3:0][3:0] w_pp;   // w_pp[i][j] = a[i] & b[j], weight i+j

`ifdef DADDA_INPUT_REG_EN
  logic [3:0] r_a, r_b;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a <= 4'h0;
      r_b <= 4'h0;
    end else begin
      r_a <= A;
      r_b <= B;
    end
  end
  assign w_a = r_a;
  assign w_b = r_b;
`else
  assign w_a = A;
  assign w_b = B;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_pp_i
    for (genvar j = 0; j < 4; j++) begin : g_pp_j
      assign w_pp[i][j] = w_a[i] & w_b[j];
    end
  end

  // Stage 1: heights 1,2,3,4,3,2,1 -> max 3
  logic w_s1_3, w_c1_4, w_s2_4, w_c2_5;
  dadda_ha u_s1_ha3 (.a(w_pp[3][0]), .b(w_pp[2][1]), .s(w_s1_3), .c(w_c1_4));
  dadda_ha u_s1_ha4 (.a(w_pp[3][1]), .b(w_pp[2][2]), .s(w_s2_4), .c(w_c2_5));

  // Stage 2: max height 3 -> 2
  logic w_s3_2, w_c3_3;
  logic w_fa1_s, w_fa1_c, w_fa2_s, w_fa2_c, w_fa3_s, w_fa3_c;
  dadda_ha u_s2_ha2 (.a(w_pp[2][0]), .b(w_pp[1][1]), .s(w_s3_2), .c(w_c3_3));
  dadda_fa u_s2_fa3 (.a(w_pp[1][2]), .b(w_pp[0][3]), .ci(w_s1_3),
                     .s(w_fa1_s), .c(w_fa1_c));
  dadda_fa u_s2_fa4 (.a(w_pp[1][3]), .b(w_c1_4), .ci(w_s2_4),
                     .s(w_fa2_s), .c(w_fa2_c));
  dadda_fa u_s2_fa5 (.a(w_pp[3][2]), .b(w_pp[2][3]), .ci(w_c2_5),
                     .s(w_fa3_s), .c(w_fa3_c));

  // Two remaining rows over columns 1..6
  logic [6:1] w_row0, w_row1;
  assign w_row0 = {w_pp[3][3], w_fa2_c, w_fa1_c, w_c3_3,  w_pp[0][2], w_pp[1][0]};
  assign w_row1 = {w_fa3_c,    w_fa3_s, w_fa2_s, w_fa1_s, w_s3_2,     w_pp[0][1]};

  // Ripple-carry CPA; w_cy[7] is the top product bit
  logic [7:1] w_cy;
  logic [7:0] w_prod;
  dadda_ha u_cpa_ha1 (.a(w_row0[1]), .b(w_row1[1]), .s(w_prod[1]), .c(w_cy[2]));
  for (genvar k = 2; k <= 6; k++) begin : g_cpa
    dadda_fa u_cpa_fa (.a(w_row0[k]), .b(w_row1[k]), .ci(w_cy[k]),
                       .s(w_prod[k]), .c(w_cy[k+1]));
  end
  assign w_cy[1]   = 1'b0;
  assign w_prod[0] = w_pp[0][0];
  assign w_prod[7] = w_cy[7];

  logic [7:0] r_product;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_product <= 8'h00;
    else          r_product <= w_prod;
  end
  assign product = r_product;

  logic w_unused;
  assign w_unused = w_cy[1];
endmodule

// File: tb/tb_dadda_multiplier.sv
// Directed and exhaustive bench for dadda_multiplier; honours DADDA_INPUT_REG_EN latency.
module tb_dadda_multiplier;
`ifdef DADDA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] A = 4'h0, B = 4'h0;
  logic [7:0] product;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  dadda_multiplier dut (
    .clock(clock), .reset_n(reset_n), .A(A), .B(B), .product(product)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: product=%0d (0x%02h) expected %0d (0x%02h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one pair, clock it, and check the product that is due LAT edges after its push.
  task automatic step(input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp, input string tag);
    A = a;
    B = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    if (exp_q.size() == LAT) chk(tag_q.pop_front(), product, exp_q.pop_front());
  endtask

  task automatic flush();
    for (int i = 0; i < LAT - 1; i++) step(4'd0, 4'd0, 8'd0, "flush");
  endtask

  initial begin
    // Reset held with nonzero operands and a running clock
    A = 4'b0101;
    B = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 chk("reset_hold", product, 8'h00);
    end
    #2 reset_n = 1'b1;

    step(4'd2,  4'd3,  8'b0000_0110, "small_2x3");
    step(4'b0101, 4'b1100, 8'b0011_1100, "mixed_5x12");
    step(4'd15, 4'd15, 8'b1110_0001, "max_15x15");
    step(4'd0,  4'd15, 8'd0,   "zero_0x15");
    step(4'd15, 4'd0,  8'd0,   "zero_15x0");
    step(4'd1,  4'd1,  8'd1,   "b2b_1x1");
    step(4'd8,  4'd8,  8'd64,  "b2b_8x8");
    step(4'd15, 4'd1,  8'd15,  "b2b_15x1");
    step(4'd7,  4'd9,  8'd63,  "b2b_7x9");

    // Operands wiggled between edges must not matter
    A = 4'd3; B = 4'd13;
    #2 A = 4'd9; B = 4'd6;
    step(4'd9, 4'd6, 8'd54, "glitch_9x6");
    step(4'd13, 4'd11, 8'd143, "b2b_13x11");
    flush();

    // Asynchronous reset mid-stream, asserted between edges
    step(4'd15, 4'd15, 8'd225, "pre_async");
    flush();
    #2 reset_n = 1'b0;
    #1 chk("async_reset", product, 8'h00);
    exp_q.delete();
    tag_q.delete();
    @(posedge clock);
    #1 chk("reset_edge", product, 8'h00);
    #2 reset_n = 1'b1;
    step(4'd12, 4'd10, 8'd120, "post_reset_12x10");
    step(4'd6,  4'd7,  8'd42,  "post_reset_6x7");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(4'(a), 4'(b), 8'(a * b), $sformatf("exh_%0dx%0d", a, b));
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
